iomem_bridge_master: RTL and testbench

//  Initiator for the PicoRAMSoC iomem bus, driven by a byte stream: parses

---
 rtl/iomem_bridge_master_pkg.sv | 24 ++
 rtl/iomem_bridge_master.sv | 150 +++++++++++++++
 tb/tb_iomem_bridge_master.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iomem_bridge_master_pkg.sv
// rtl/iomem_bridge_master_pkg.sv - opcode/response byte constants and FSM states for the iomem bridge
package iomem_bridge_master_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_TO  = 8'h54;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STRB,
    ST_DATA,
    ST_BUS,
    ST_RESP,
    ST_RDAT
  } state_t;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WR) || (b == OP_RD);
  endfunction

endpackage

// File: rtl/iomem_bridge_master.sv
// rtl/iomem_bridge_master.sv - byte-stream driven iomem initiator (W/R packets, status + read data back)
// Optional inter-byte receive abort is built only with IOMEM_BRIDGE_RXTO_EN defined.
module iomem_bridge_master
  import iomem_bridge_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RX_IDLE_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state, state_next;
  logic [1:0]    bcnt;
  logic [TW-1:0] tcnt;
  logic          is_rd;
  logic [7:0]    rsp;
  logic [31:0]   rdata_q;
  logic          rx_fire, tx_fire, last_byte, bus_to, rx_abort;

  assign rx_ready  = resetn && (state inside {ST_IDLE, ST_ADDR, ST_STRB, ST_DATA});
  assign busy      = (state != ST_IDLE);
  assign rx_fire   = rx_valid & rx_ready;
  assign tx_fire   = tx_valid & tx_ready;
  assign last_byte = (bcnt == 2'd3);
  assign bus_to    = (tcnt == TW'(TIMEOUT_CYCLES));

`ifdef IOMEM_BRIDGE_RXTO_EN
  localparam int IW = $clog2(RX_IDLE_CYCLES + 1);
  logic [IW-1:0] icnt;
  logic          rx_wait;

  assign rx_wait  = state inside {ST_ADDR, ST_STRB, ST_DATA};
  assign rx_abort = rx_wait && !rx_fire && (icnt == IW'(RX_IDLE_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      icnt <= '0;
    else if (!rx_wait || rx_fire || (state_next != state))
      icnt <= '0;
    else
      icnt <= icnt + IW'(1);
  end
`else
  localparam int rx_idle_unused = RX_IDLE_CYCLES;
  assign rx_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (rx_fire) state_next = is_opcode(rx_data) ? ST_ADDR : ST_RESP;
      ST_ADDR: if (rx_fire && last_byte) state_next = is_rd ? ST_BUS : ST_STRB;
      ST_STRB: if (rx_fire) state_next = ST_DATA;
      ST_DATA: if (rx_fire && last_byte) state_next = ST_BUS;
      ST_BUS:  if (iomem_ready || bus_to) state_next = ST_RESP;
      ST_RESP: if (tx_fire) state_next = (is_rd && rsp == RSP_OK) ? ST_RDAT : ST_IDLE;
      ST_RDAT: if (tx_fire && last_byte) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (rx_abort) state_next = ST_RESP;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bcnt        <= '0;
      tcnt        <= '0;
      is_rd       <= 1'b0;
      rsp         <= RSP_OK;
      rdata_q     <= '0;
      iomem_valid <= 1'b0;
      iomem_wstrb <= '0;
      iomem_addr  <= '0;
      iomem_wdata <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
    end else begin
      // One byte counter shared by ADDR/DATA/RDAT, restarted on every state change
      if (state_next != state)
        bcnt <= '0;
      else if ((rx_fire && (state == ST_ADDR || state == ST_DATA)) || (tx_fire && state == ST_RDAT))
        bcnt <= bcnt + 2'd1;

      case (state)
        ST_IDLE: if (rx_fire) begin
          is_rd <= (rx_data == OP_RD);
          rsp   <= is_opcode(rx_data) ? RSP_OK : RSP_ERR;
          if (rx_data == OP_RD) iomem_wstrb <= '0;
        end
        ST_ADDR: if (rx_fire) iomem_addr  <= {iomem_addr[23:0], rx_data};
        ST_STRB: if (rx_fire) iomem_wstrb <= rx_data[3:0];
        ST_DATA: if (rx_fire) iomem_wdata <= {iomem_wdata[23:0], rx_data};
        ST_BUS: begin
          // Ready on the expiry cycle still counts as a completed transfer
          if (iomem_ready) begin
            iomem_valid <= 1'b0;
            rdata_q     <= iomem_rdata;
            rsp         <= RSP_OK;
          end else if (bus_to) begin
            iomem_valid <= 1'b0;
            rsp         <= RSP_TO;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_RESP, ST_RDAT: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            if (state == ST_RESP) begin
              tx_data <= rsp;
            end else begin
              tx_data <= rdata_q[31:24];
              rdata_q <= {rdata_q[23:0], 8'h00};
            end
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
          end
        end
        default: ;
      endcase

      if (state != ST_BUS && state_next == ST_BUS) begin
        iomem_valid <= 1'b1;
        tcnt        <= TW'(1);
      end
      if (rx_abort) rsp <= RSP_ERR;
    end
  end

endmodule

// File: tb/tb_iomem_bridge_master.sv
// tb/tb_iomem_bridge_master.sv - vector table, corner sequences and randomized packets vs a packet-level model
module tb_iomem_bridge_master;
  import iomem_bridge_master_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        iomem_valid, iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  iomem_bridge_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .busy(busy)
  );

  // sink: ready forced low, random, or always high
  logic tx_hold = 1'b0, tx_rand_en = 1'b0, tx_rnd = 1'b1;
  always @(negedge clk) tx_rnd <= ($urandom_range(0, 2) != 0);
  assign tx_ready = tx_hold ? 1'b0 : (tx_rand_en ? tx_rnd : 1'b1);

  // responder: 16-word memory at 0x03xxxxxx, ready during the lat-th valid cycle (lat=0: never)
  int          lat = 2;
  logic [31:0] rmem [16];
  logic [7:0]  vc;
  assign iomem_ready = iomem_valid && (iomem_addr[31:24] == 8'h03) && (int'(vc) + 1 == lat);
  assign iomem_rdata = rmem[iomem_addr[5:2]];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vc <= '0;
      for (int i = 0; i < 16; i++) rmem[i] <= '0;
    end else begin
      vc <= (iomem_valid && !iomem_ready) ? vc + 8'd1 : 8'd0;
      if (iomem_valid && iomem_ready)
        for (int b = 0; b < 4; b++)
          if (iomem_wstrb[b]) rmem[iomem_addr[5:2]][8*b +: 8] <= iomem_wdata[8*b +: 8];
    end
  end

  // bus / stream monitors
  int          txn_cnt = 0, vcyc = 0, rxn = 0, stab_bad = 0, txs_bad = 0;
  logic        prev_v = 1'b0, prev_txv = 1'b0, prev_txr = 1'b0;
  logic [31:0] prev_a = '0, prev_d = '0;
  logic [3:0]  prev_s = '0, cap_s = '0;
  logic [7:0]  prev_txd = '0;
  logic [7:0]  rxb [1024];
  always @(posedge clk) begin
    prev_v <= iomem_valid; prev_a <= iomem_addr; prev_d <= iomem_wdata; prev_s <= iomem_wstrb;
    if (iomem_valid && !prev_v) begin txn_cnt <= txn_cnt + 1; cap_s <= iomem_wstrb; end
    if (iomem_valid) vcyc <= vcyc + 1;
    if (iomem_valid && prev_v && {iomem_addr, iomem_wdata, iomem_wstrb} != {prev_a, prev_d, prev_s})
      stab_bad <= stab_bad + 1;
    prev_txv <= tx_valid; prev_txr <= tx_ready; prev_txd <= tx_data;
    if (resetn && prev_txv && !prev_txr && (!tx_valid || tx_data != prev_txd)) txs_bad <= txs_bad + 1;
    if (tx_valid && tx_ready) begin rxb[rxn % 1024] <= tx_data; rxn <= rxn + 1; end
  end

  int vecs = 0, errs = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // packet-level reference: {byte count, response bytes first-byte-most-significant}
  logic [31:0] mmem [16];
  task automatic model_pkt(input logic [7:0] op, input logic [31:0] a, input logic [7:0] s,
                           input logic [31:0] d, input int l, output logic [43:0] r);
    if (op != OP_WR && op != OP_RD)               r = {4'd1, 32'd0, RSP_ERR};
    else if (a[31:24] != 8'h03 || l < 1 || l > TMO) r = {4'd1, 32'd0, RSP_TO};
    else if (op == OP_WR) begin
      for (int b = 0; b < 4; b++) if (s[b]) mmem[a[5:2]][8*b +: 8] = d[8*b +: 8];
      r = {4'd1, 32'd0, RSP_OK};
    end else r = {4'd5, RSP_OK, mmem[a[5:2]]};
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b; rx_valid = 1'b1;
    while (!rx_ready && n < 2000) begin @(negedge clk); n++; end
    if (!rx_ready) chk("rx_ready_wait", rx_ready, 1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [7:0] s, input logic [31:0] d);
    send_byte(op);
    if (op == OP_WR || op == OP_RD) begin
      for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
      if (op == OP_WR) begin
        send_byte(s);
        for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
      end
    end
  endtask

  task automatic collect(input int n0, output logic [43:0] got);
    int n = 0, k;
    logic [39:0] bytes = '0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    if (busy) chk("idle_wait", busy, 0);
    @(negedge clk);
    k = rxn - n0;
    for (int i = 0; i < k && i < 5; i++) bytes = {bytes[31:0], rxb[(n0 + i) % 1024]};
    got = {(k > 15) ? 4'd15 : 4'(k), bytes};
  endtask

  task automatic run(input logic [7:0] op, input logic [31:0] a, input logic [7:0] s, input logic [31:0] d,
                     input int l, output logic [43:0] got, output logic [43:0] mdl, output int dtx, output int dcyc);
    int n0, t0, c0;
    lat = l; n0 = rxn; t0 = txn_cnt; c0 = vcyc;
    issue(op, a, s, d);
    collect(n0, got);
    dtx = txn_cnt - t0; dcyc = vcyc - c0;
    model_pkt(op, a, s, d, l, mdl);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [7:0]  strb;
    logic [31:0] data;
    int          lat;
    logic [43:0] exp;
  } vec_t;
  vec_t tbl [12];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [43:0] got, mdl;
    int dtx, dcyc, k, bad, n0;
    logic [7:0] hold, op;
    logic [31:0] a;
    logic is_pkt;

    tbl[0]  = '{OP_WR, 32'h0300_0000, 8'h0F, 32'h0000_A55A, 2, {4'd1, 32'd0, RSP_OK}};
    tbl[1]  = '{OP_RD, 32'h0300_0000, 8'h00, 32'h0,         2, {4'd5, RSP_OK, 32'h0000_A55A}};
    tbl[2]  = '{OP_RD, 32'h0400_0000, 8'h00, 32'h0,         2, {4'd1, 32'd0, RSP_TO}};
    tbl[3]  = '{8'h41, 32'h0,         8'h00, 32'h0,         2, {4'd1, 32'd0, RSP_ERR}};
    tbl[4]  = '{OP_WR, 32'h0300_0000, 8'h03, 32'h1234_5678, 2, {4'd1, 32'd0, RSP_OK}};
    tbl[5]  = '{OP_RD, 32'h0300_0000, 8'h00, 32'h0,         2, {4'd5, RSP_OK, 32'h0000_5678}};
    tbl[6]  = '{OP_WR, 32'h0300_0004, 8'hF0, 32'hFFFF_FFFF, 2, {4'd1, 32'd0, RSP_OK}};
    tbl[7]  = '{OP_RD, 32'h0300_0004, 8'h00, 32'h0,         2, {4'd5, RSP_OK, 32'h0000_0000}};
    tbl[8]  = '{OP_RD, 32'h0300_0000, 8'h00, 32'h0,         8, {4'd5, RSP_OK, 32'h0000_5678}};
    tbl[9]  = '{OP_RD, 32'h0300_0000, 8'h00, 32'h0,         9, {4'd1, 32'd0, RSP_TO}};
    tbl[10] = '{OP_WR, 32'h0300_0008, 8'h1C, 32'hAABB_CCDD, 1, {4'd1, 32'd0, RSP_OK}};
    tbl[11] = '{OP_RD, 32'h0300_0008, 8'h00, 32'h0,         1, {4'd5, RSP_OK, 32'hAABB_0000}};
    for (int i = 0; i < 16; i++) mmem[i] = '0;

    // reset state
    #12;
    chk("rst_iomem", {iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata}, '0);
    chk("rst_tx", {tx_valid, tx_data}, '0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_ready", rx_ready, 0);
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    chk("idle_rx_ready", rx_ready, 1);

    foreach (tbl[i]) begin
      run(tbl[i].op, tbl[i].addr, tbl[i].strb, tbl[i].data, tbl[i].lat, got, mdl, dtx, dcyc);
      is_pkt = (tbl[i].op == OP_WR || tbl[i].op == OP_RD);
      chk($sformatf("vec%0d_resp", i), got, tbl[i].exp);
      chk($sformatf("vec%0d_txns", i), dtx, is_pkt ? 1 : 0);
      if (is_pkt) chk($sformatf("vec%0d_wstrb", i), cap_s, (tbl[i].op == OP_WR) ? tbl[i].strb[3:0] : 4'h0);
      if (tbl[i].exp[7:0] == RSP_TO) chk($sformatf("vec%0d_valid_cycles", i), dcyc, TMO);
    end

    // read latency with a registered-ready responder
    lat = 2; n0 = rxn;
    issue(OP_RD, 32'h0300_0000, 8'h00, 32'h0);
    k = 0;
    while (!tx_valid && k < 20) begin @(posedge clk); #1; k++; end
    chk("read_latency", k, 3);
    collect(n0, got);
    chk("latency_resp", got, {4'd5, RSP_OK, 32'h0000_5678});

    // sink stall during a read response
    tx_hold = 1'b1; n0 = rxn;
    issue(OP_RD, 32'h0300_0008, 8'h00, 32'h0);
    k = 0;
    while (!tx_valid && k < 50) begin @(negedge clk); k++; end
    hold = tx_data; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== hold || rx_ready) bad++;
    end
    chk("stall_hold", bad, 0);
    chk("stall_first", hold, RSP_OK);
    tx_hold = 1'b0;
    collect(n0, got);
    chk("stall_resp", got, {4'd5, RSP_OK, 32'hAABB_0000});

    // randomized packets against the model
    tx_rand_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 19);
      op = (k < 9) ? OP_WR : (k < 17) ? OP_RD : 8'($urandom);
      if (k >= 17 && is_opcode(op)) op = 8'h41;
      a = ($urandom_range(0, 5) == 0) ? {8'h04, 24'($urandom)} : {8'h03, 18'h0, 4'($urandom_range(0, 15)), 2'b00};
      run(op, a, 8'($urandom), 32'($urandom), $urandom_range(1, 10), got, mdl, dtx, dcyc);
      chk($sformatf("rand%0d_resp", i), got, mdl);
      chk($sformatf("rand%0d_txns", i), dtx, is_opcode(op) ? 1 : 0);
    end
    tx_rand_en = 1'b0;

    // reset while a bus cycle is outstanding
    lat = 0; n0 = rxn;
    issue(OP_RD, 32'h0400_0000, 8'h00, 32'h0);
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", iomem_valid, 1);
    #2 resetn = 1'b0;
    #1;
    chk("reset_async", {iomem_valid, tx_valid, busy, rx_ready}, 4'b0000);
    @(negedge clk); resetn = 1'b1;
    for (int i = 0; i < 16; i++) mmem[i] = '0;
    repeat (4) @(negedge clk);
    chk("reset_no_resp", rxn - n0, 0);
    run(OP_WR, 32'h0300_0010, 8'h03, 32'h1122_3344, 2, got, mdl, dtx, dcyc);
    chk("post_reset_resp", got, {4'd1, 32'd0, RSP_OK});
    chk("post_reset_wstrb", cap_s, 4'h3);
    run(OP_RD, 32'h0300_0010, 8'h00, 32'h0, 2, got, mdl, dtx, dcyc);
    chk("post_reset_read", got, {4'd5, RSP_OK, 32'h0000_3344});

    chk("iomem_stable", stab_bad, 0);
    chk("tx_stable", txs_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
